// File: rtl/sub_chain_pipe.sv
// sub_chain_pipe
//   Multi-lane registered bit chain. Each lane shifts its input through DEPTH
//   stages. The output register can invert the last stage. A valid/ready
//   snapshot port captures every stage as one packed word. A saturating
//   counter records the cycles in which the outputs changed.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_bits     [LANES]        lane inputs
//   invert_en   1 = output register stores the inverted last stage
//   out_bits    [LANES]        registered lane outputs
//   snap_req    capture request
//   snap_valid  snapshot held
//   snap_ready  consumer accepts the snapshot
//   snap_data   [LANES*DEPTH]  packed stages, bit l*DEPTH+k = stage[l][k]
//   cnt_clr     synchronous clear of the toggle counter
//   toggle_cnt  [CNT_W]        number of cycles in which out_bits changed
//   toggle_sat  toggle_cnt is all-ones
//
// Snapshot FSM
//   state  | meaning
//   S_IDLE | nothing held, snap_valid=0, waiting for snap_req
//   S_HOLD | snapshot held stable, snap_valid=1, waiting for snap_ready
module sub_chain_pipe #(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_bits,
  input  logic                   invert_en,
  output logic [LANES-1:0]       out_bits,
  input  logic                   snap_req,
  output logic                   snap_valid,
  input  logic                   snap_ready,
  output logic [LANES*DEPTH-1:0] snap_data,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       toggle_cnt,
  output logic                   toggle_sat
);

  localparam int SW = LANES * DEPTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } snap_state_t;

  // Stages are stored directly in snapshot packing order, so a capture is a
  // plain copy of the register.
  logic [SW-1:0]    stage_q;
  logic [SW-1:0]    stage_d;
  logic [LANES-1:0] last_stage;
  logic [LANES-1:0] out_d;
  logic             out_change;

  snap_state_t      state_q;
  snap_state_t      state_d;
  logic             capture;

  always_comb begin
    stage_d    = '0;
    last_stage = '0;
    for (int l = 0; l < LANES; l++) begin
      stage_d[l*DEPTH] = in_bits[l];
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[l*DEPTH+k] = stage_q[l*DEPTH+k-1];
      end
      last_stage[l] = stage_q[l*DEPTH+DEPTH-1];
    end
  end

  assign out_d      = last_stage ^ {LANES{invert_en}};
  assign out_change = (out_d != out_bits);

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q  <= '0;
      out_bits <= '0;
    end else begin
      stage_q  <= stage_d;
      out_bits <= out_d;
    end
  end

  // Clear wins over a simultaneous increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      toggle_cnt <= '0;
    end else if (out_change && !toggle_sat) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end

  assign toggle_sat = &toggle_cnt;

  // Snapshot FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (snap_req) state_d = S_HOLD;
      S_HOLD: if (snap_ready && !snap_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Snapshot FSM: outputs. A request while holding is only honoured on the
  // accepting edge (back-to-back); otherwise it is dropped.
  always_comb begin
    snap_valid = 1'b0;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: capture = snap_req;
      S_HOLD: begin
        snap_valid = 1'b1;
        capture    = snap_req && snap_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_data <= '0;
    end else if (capture) begin
      snap_data <= stage_q;
    end
  end

endmodule

// File: tb/tb_sub_chain_pipe.sv
module tb_sub_chain_pipe;

  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int SW    = LANES * DEPTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LANES-1:0] in_bits = '0;
  logic             invert_en = 1'b0;
  logic [LANES-1:0] out_bits;
  logic             snap_req = 1'b0;
  logic             snap_valid;
  logic             snap_ready = 1'b0;
  logic [SW-1:0]    snap_data;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] toggle_cnt;
  logic             toggle_sat;

  int checks = 0;
  int failures = 0;

  sub_chain_pipe #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_bits(in_bits), .invert_en(invert_en),
    .out_bits(out_bits), .snap_req(snap_req), .snap_valid(snap_valid),
    .snap_ready(snap_ready), .snap_data(snap_data), .cnt_clr(cnt_clr),
    .toggle_cnt(toggle_cnt), .toggle_sat(toggle_sat)
  );

  always #5 clk = ~clk;

  // Reference model: hist[k] is the in_bits value sampled k+1 edges ago,
  // i.e. the contents of stage k of every lane.
  logic [LANES-1:0] hist[$];
  logic [LANES-1:0] m_out;
  int               m_cnt;
  bit               m_valid;
  logic [SW-1:0]    m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] pack_hist();
    logic [SW-1:0] w;
    w = '0;
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < DEPTH; k++)
        w[l*DEPTH+k] = hist[k][l];
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back('0);
    m_out   = '0;
    m_cnt   = 0;
    m_valid = 0;
    m_data  = '0;
  endtask

  task automatic model_edge();
    logic [LANES-1:0] nout;
    if (rst) begin
      model_reset();
      return;
    end
    nout = hist[DEPTH-1] ^ {LANES{invert_en}};
    if (!m_valid) begin
      if (snap_req) begin
        m_data  = pack_hist();
        m_valid = 1;
      end
    end else if (snap_ready) begin
      if (snap_req) m_data = pack_hist();
      else m_valid = 0;
    end
    if (cnt_clr) m_cnt = 0;
    else if (nout != m_out && m_cnt < CMAX) m_cnt++;
    m_out = nout;
    hist.push_front(in_bits);
    void'(hist.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_bits", 32'(out_bits), 32'(m_out));
    chk("snap_valid", 32'(snap_valid), 32'(m_valid));
    chk("snap_data", 32'(snap_data), 32'(m_data));
    chk("toggle_cnt", 32'(toggle_cnt), 32'(m_cnt));
    chk("toggle_sat", 32'(toggle_sat), 32'(m_cnt == CMAX));
  endtask

  task automatic idle_inputs();
    rst = 0; in_bits = '0; invert_en = 0;
    snap_req = 0; snap_ready = 0; cnt_clr = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) tick();
    rst = 0;
  endtask

  logic [SW-1:0] held;
  logic [3:0]    pat;

  initial begin
    model_reset();

    // Reset with every other input active
    in_bits = 2'b11; invert_en = 1; snap_req = 1; snap_ready = 1; cnt_clr = 0;
    do_reset(2);
    chk("rst_out", 32'(out_bits), 32'd0);
    chk("rst_valid", 32'(snap_valid), 32'd0);
    chk("rst_data", 32'(snap_data), 32'd0);
    chk("rst_cnt", 32'(toggle_cnt), 32'd0);
    chk("rst_sat", 32'(toggle_sat), 32'd0);

    // Latency: single-edge pulse on lane 0
    idle_inputs();
    in_bits = 2'b01;
    tick();
    in_bits = 2'b00;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      chk("lat_early", 32'(out_bits), 32'd0);
    end
    tick();
    chk("lat_pulse", 32'(out_bits), 32'b01);
    tick();
    chk("lat_after", 32'(out_bits), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("lat_cnt", 32'(toggle_cnt), 32'd2);

    // Inversion right after reset
    idle_inputs(); do_reset(1);
    invert_en = 1;
    tick();
    chk("inv_first", 32'(out_bits), 32'b11);
    for (int i = 0; i < 6; i++) tick();
    chk("inv_hold", 32'(out_bits), 32'b11);
    chk("inv_cnt", 32'(toggle_cnt), 32'd1);

    // Snapshot hold: lane0 stages [3:0] = 1011, oldest sample first
    idle_inputs(); do_reset(1);
    pat = 4'b1011;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      in_bits = {1'b0, pat[k]};
      tick();
    end
    in_bits = 2'b00;
    snap_req = 1;
    tick();
    snap_req = 0;
    chk("snap_valid_up", 32'(snap_valid), 32'd1);
    chk("snap_word", 32'(snap_data), 32'h0B);
    for (int i = 0; i < 3; i++) begin
      in_bits = 2'($urandom_range(0, 3));
      tick();
      chk("snap_stable", 32'(snap_data), 32'h0B);
    end
    snap_ready = 1;
    tick();
    snap_ready = 0;
    chk("snap_accept", 32'(snap_valid), 32'd0);

    // Back-to-back recapture, then a request without ready is ignored
    for (int i = 0; i < 4; i++) begin
      in_bits = 2'($urandom_range(0, 3));
      tick();
    end
    snap_req = 1;
    tick();
    in_bits = 2'b11;
    snap_ready = 1;
    tick();
    chk("b2b_valid", 32'(snap_valid), 32'd1);
    held = snap_data;
    snap_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_bits = 2'($urandom_range(0, 3));
      tick();
      chk("b2b_nodrop", 32'(snap_data), 32'(held));
    end
    snap_req = 0;
    snap_ready = 1;
    tick();
    snap_ready = 0;

    // Saturation, clear on a toggling cycle, reset while holding
    idle_inputs(); do_reset(1);
    for (int i = 0; i < 16; i++) begin
      in_bits = (i % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    chk("sat_cnt", 32'(toggle_cnt), 32'(CMAX));
    chk("sat_flag", 32'(toggle_sat), 32'd1);
    cnt_clr = 1;
    in_bits = ~in_bits;
    tick();
    cnt_clr = 0;
    chk("clr_cnt", 32'(toggle_cnt), 32'd0);
    chk("clr_sat", 32'(toggle_sat), 32'd0);
    snap_req = 1;
    tick();
    snap_req = 0;
    chk("hold_before_rst", 32'(snap_valid), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_in_hold", 32'(snap_valid), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      in_bits    = 2'($urandom_range(0, 3));
      invert_en  = ($urandom_range(0, 7) == 0) ? ~invert_en : invert_en;
      snap_req   = ($urandom_range(0, 3) == 0);
      snap_ready = ($urandom_range(0, 2) == 0);
      cnt_clr    = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub_chain_pipe.md
# sub_chain_pipe

Parametrised multi-lane bit-chain block for the coverage sandbox. Each lane passes its input bit through a DEPTH-stage registered chain, with a selectable inversion at the output. The block provides a valid/ready snapshot port that captures every chain stage as a packed word, and a saturating toggle counter on the outputs. It replaces single-lane, fixed-depth chain blocks in the coverage test designs.

## Interface

- LANES, 2, number of independent bit lanes (≥1)
- DEPTH, 4, registered stages per lane (≥1)
- CNT_W, 8, toggle counter width (≥2)

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_bits  input  LANES  lane inputs
- invert_en  input  1  1 = output register stores inverted last stage
- out_bits  output  LANES  registered lane outputs
- snap_req  input  1  request capture of all stages
- snap_valid  output  1  snapshot held
- snap_ready  input  1  consumer accepts snapshot
- snap_data  output  LANES*DEPTH  packed stage snapshot
- cnt_clr  input  1  synchronous clear of toggle counter
- toggle_cnt  output  CNT_W  cycles in which out_bits changed
- toggle_sat  output  1  toggle_cnt at all-ones

## Operation

- Chain: per lane l, stage[l][0] <= in_bits[l]; stage[l][k] <= stage[l][k-1] for k=1..DEPTH-1.
- Output: out_bits[l] <= stage[l][DEPTH-1] ^ invert_en.
- Packing: snap_data bit l*DEPTH+k = stage[l][k] (lane 0 in LSBs; stage 0 is lowest bit of each lane field).
- Snapshot FSM, two states:
  - IDLE: snap_valid=0. snap_req=1 at edge -> snap_data <= packed word of current stage values (pre-edge), -> HOLD.
  - HOLD: snap_valid=1, snap_data stable. snap_valid&snap_ready at edge: if snap_req=1 same edge, recapture and stay HOLD (back-to-back); else -> IDLE. snap_req without snap_ready in HOLD is ignored (no queueing).
- Toggle counter: a cycle counts when next out_bits != current out_bits (any number of lanes = one count). Saturates at 2^CNT_W-1; no wrap. cnt_clr=1 -> toggle_cnt <= 0; cnt_clr beats a simultaneous increment.
- toggle_sat is combinational: toggle_cnt == all-ones.
- invert_en change takes effect at the next edge and is counted as a toggle if out_bits changes.

## Timing

- Reset (rst=1 at edge): all stages, out_bits, snap_data, toggle_cnt = 0; snap_valid = 0; FSM IDLE. Reset overrides every other input.
- Reset mid-snapshot: snap_valid drops at that edge; the held snapshot is lost, with no handshake.
- Latency: in_bits sampled at edge n appears on out_bits after edge n+DEPTH.
- Snapshot: snap_valid rises at the edge after which snap_req was sampled high, i.e. one-cycle capture latency. Accept completes at the edge where valid&ready is seen.
- First edge after rst deasserts with invert_en=1: out_bits becomes all-ones, and this counts one toggle.
- The snapshot port has no combinational path from snap_ready to snap_valid or snap_data.

## Test plan

- Reset: hold rst 2 cycles with in_bits=2'b11, invert_en=1, snap_req=1 -> out_bits=0, snap_valid=0, snap_data=0, toggle_cnt=0, toggle_sat=0.
- Latency (LANES=2, DEPTH=4, invert_en=0): in_bits=2'b01 for the single edge n, 0 otherwise -> out_bits=2'b01 only between edges n+4 and n+5; toggle_cnt=2.
- Inversion: after reset, invert_en=1, in_bits=0 -> out_bits=2'b11 after the first edge and stays there; toggle_cnt=1.
- Snapshot hold: shift lane0 so stage[0][3:0]=4'b1011, lane1=0; pulse snap_req -> snap_valid=1, snap_data=8'h0B. Hold snap_ready=0 for 3 cycles while the chain keeps shifting -> data stable. Raise snap_ready -> snap_valid=0 next cycle.
- Back-to-back: in HOLD, snap_req=1 and snap_ready=1 at the same edge -> snap_valid stays 1 and snap_data updates to the new packed stages. Repeat with snap_req=1, snap_ready=0 -> data unchanged.
- Saturation (CNT_W=3): toggle in_bits every cycle for 10 output changes -> toggle_cnt=7, toggle_sat=1. cnt_clr=1 on a toggling cycle -> toggle_cnt=0, toggle_sat=0. Reset asserted in HOLD -> snap_valid=0 next cycle.
